// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver with runtime parity, valid/ready output, overrun and break recovery.
// Ports:
//   clk, reset      system clock, asynchronous active-high reset
//   en              oversample tick from the shared baud generator, 1 clk wide
//   in              raw serial line (idles high, asynchronous to clk)
//   parityMode      00/11 none, 01 even, 10 odd; captured when a start bit is accepted
//   data, valid     received word and its valid flag
//   ready           consumer accept, a transfer happens on valid && ready
//   parityErr       1-clk pulse with the delivery of a word whose parity mismatched
//   frameErr        1-clk pulse when a stop bit samples low
//   overrun         1-clk pulse when a frame completes while the previous word is still pending
// Build option: define UART_RX_MAJORITY_EN to take each bit as the majority of the last three
//   en-qualified line values instead of the single centre sample.
module uart_rx_cfg #(
  parameter int Oversample = 16,
  parameter int DataBits   = 8,
  parameter int StopBits   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic                in,
  input  logic [1:0]          parityMode,
  output logic [DataBits-1:0] data,
  output logic                valid,
  input  logic                ready,
  output logic                parityErr,
  output logic                frameErr,
  output logic                overrun
);
  localparam int CW = $clog2(Oversample);
  localparam int IW = $clog2(DataBits + 1);
  localparam logic [CW-1:0] HALF = CW'(Oversample / 2 - 1);
  localparam logic [CW-1:0] FULL = CW'(Oversample - 1);
  localparam logic [IW-1:0] LAST = IW'(DataBits - 1);
  localparam logic [IW-1:0] SLAST = IW'(StopBits - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t state_q, state_d;
  logic [1:0] sync_q;
  logic prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [DataBits-1:0] buf_q, buf_d, data_q, data_d;
  logic [1:0] pmode_q, pmode_d;
  logic mis_q, mis_d, valid_q, valid_d, perr_q, perr_d, ferr_q, ferr_d, ovr_q, ovr_d;
  logic line, smp, done, ferr, par_en;
  assign line = sync_q[1];
  assign par_en = ^pmode_q;
`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;
  always_ff @(posedge clk or posedge reset)
    if (reset) hist_q <= 2'b11;
    else if (en) hist_q <= {hist_q[0], line};
  assign smp = (hist_q[1] & hist_q[0]) | (hist_q[1] & line) | (hist_q[0] & line);
`else
  assign smp = line;
`endif
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    buf_d = buf_q;
    pmode_d = pmode_q;
    mis_d = mis_q;
    done = 1'b0;
    ferr = 1'b0;
    if (en) begin
      if (state_q inside {START, DATA, PARITY, STOP} && cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else case (state_q)
        IDLE: if (prev_q && !line) begin
          state_d = START;
          cnt_d = HALF;
        end
        START: if (smp) state_d = IDLE;
        else begin
          state_d = DATA;
          cnt_d = FULL;
          idx_d = '0;
          pmode_d = parityMode;
          mis_d = 1'b0;
        end
        DATA: begin
          buf_d = {smp, buf_q[DataBits-1:1]};
          cnt_d = FULL;
          idx_d = idx_q + 1'b1;
          if (idx_q == LAST) begin
            state_d = par_en ? PARITY : STOP;
            idx_d = '0;
          end
        end
        PARITY: begin
          mis_d = smp ^ (^buf_q) ^ pmode_q[1];
          state_d = STOP;
          cnt_d = FULL;
        end
        STOP: if (!smp) begin
          ferr = 1'b1;
          state_d = BREAK;
        end else if (idx_q == SLAST) begin
          done = 1'b1;
          state_d = IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
          cnt_d = FULL;
        end
        BREAK: if (line) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end
  always_comb begin
    valid_d = valid_q & ~ready;
    data_d = data_q;
    perr_d = 1'b0;
    ferr_d = ferr;
    ovr_d = done & valid_d;
    if (done && !valid_d) begin
      data_d = buf_q;
      valid_d = 1'b1;
      perr_d = mis_q;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      sync_q <= 2'b11;
      prev_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      buf_q <= '0;
      pmode_q <= '0;
      mis_q <= 1'b0;
      data_q <= '0;
      valid_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], in};
      if (en) prev_q <= line;
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      buf_q <= buf_d;
      pmode_q <= pmode_d;
      mis_q <= mis_d;
      data_q <= data_d;
      valid_q <= valid_d;
      perr_q <= perr_d;
      ferr_q <= ferr_d;
      ovr_q <= ovr_d;
    end
  assign data = data_q;
  assign valid = valid_q;
  assign parityErr = perr_q;
  assign frameErr = ferr_q;
  assign overrun = ovr_q;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: directed frames against uart_rx_cfg (8 data bits, 1 stop bit, 16x oversample).
module tb_uart_rx_cfg;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic en = 1'b0;
  logic in = 1'b1;
  logic ready = 1'b0;
  logic [1:0] parityMode = 2'b00;
  logic [7:0] data;
  logic valid, parityErr, frameErr, overrun;
  int total = 0;
  int bad = 0;
  int n_acc = 0, n_perr = 0, n_ferr = 0, n_ovr = 0, n_vclk = 0;
  int b_acc, b_perr, b_ferr, b_ovr, b_vclk;
  logic [7:0] last_acc = 8'h00;
  uart_rx_cfg #(.Oversample(16), .DataBits(8), .StopBits(1)) dut (
    .clk(clk), .reset(reset), .en(en), .in(in), .parityMode(parityMode),
    .data(data), .valid(valid), .ready(ready),
    .parityErr(parityErr), .frameErr(frameErr), .overrun(overrun)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (valid && ready) begin
      n_acc++;
      last_acc = data;
    end
    if (valid) n_vclk++;
    if (parityErr) n_perr++;
    if (frameErr) n_ferr++;
    if (overrun) n_ovr++;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic snap();
    b_acc = n_acc;
    b_perr = n_perr;
    b_ferr = n_ferr;
    b_ovr = n_ovr;
    b_vclk = n_vclk;
  endtask
  task automatic tick(input logic v);
    in = v;
    en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic bits(input logic v, input int n);
    repeat (16 * n) tick(v);
  endtask
  task automatic frame(input logic [7:0] d, input int par, input logic stp, input int gbit);
    bits(1'b0, 1);
    for (int j = 0; j < 8; j++)
      for (int t = 0; t < 16; t++) tick((j == gbit && t == 8) ? ~d[j] : d[j]);
    if (par >= 0) bits(par[0], 1);
    bits(stp, 1);
  endtask
  initial begin
    logic [7:0] exp_glitch;
    @(posedge clk);
    #1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid", valid, 0);
    check("rst_data", data, 0);
    check("rst_perr", parityErr, 0);
    check("rst_ferr", frameErr, 0);
    check("rst_ovr", overrun, 0);
    reset = 1'b0;
    ready = 1'b1;
    bits(1'b1, 2);
    snap();
    frame(8'hA5, -1, 1'b1, -1);
    bits(1'b1, 1);
    check("a5_acc", n_acc - b_acc, 1);
    check("a5_data", last_acc, 8'hA5);
    check("a5_vclk", n_vclk - b_vclk, 1);
    check("a5_errs", (n_perr - b_perr) + (n_ferr - b_ferr) + (n_ovr - b_ovr), 0);
    parityMode = 2'b01;
    snap();
    frame(8'h03, 1, 1'b1, -1);
    bits(1'b1, 1);
    check("even_bad_acc", n_acc - b_acc, 1);
    check("even_bad_data", last_acc, 8'h03);
    check("even_bad_perr", n_perr - b_perr, 1);
    snap();
    frame(8'h03, 0, 1'b1, -1);
    bits(1'b1, 1);
    check("even_ok_perr", n_perr - b_perr, 0);
    check("even_ok_acc", n_acc - b_acc, 1);
    parityMode = 2'b10;
    snap();
    frame(8'h03, 1, 1'b1, -1);
    bits(1'b1, 1);
    check("odd_ok_perr", n_perr - b_perr, 0);
    check("odd_ok_data", last_acc, 8'h03);
    parityMode = 2'b00;
    snap();
    frame(8'h55, -1, 1'b0, -1);
    bits(1'b0, 19);
    bits(1'b1, 2);
    check("brk_ferr", n_ferr - b_ferr, 1);
    check("brk_acc", n_acc - b_acc, 0);
    snap();
    frame(8'h12, -1, 1'b1, -1);
    bits(1'b1, 1);
    check("after_brk_acc", n_acc - b_acc, 1);
    check("after_brk_data", last_acc, 8'h12);
    snap();
    repeat (3) tick(1'b0);
    bits(1'b1, 2);
    check("glitch_acc", n_acc - b_acc, 0);
    check("glitch_errs", (n_perr - b_perr) + (n_ferr - b_ferr) + (n_ovr - b_ovr), 0);
    ready = 1'b0;
    snap();
    frame(8'h11, -1, 1'b1, -1);
    frame(8'h22, -1, 1'b1, -1);
    bits(1'b1, 1);
    check("ovr_valid", valid, 1);
    check("ovr_data", data, 8'h11);
    check("ovr_pulse", n_ovr - b_ovr, 1);
    check("ovr_perr", n_perr - b_perr, 0);
    ready = 1'b1;
    @(posedge clk);
    #1;
    check("ovr_acc", n_acc - b_acc, 1);
    check("ovr_acc_data", last_acc, 8'h11);
    check("ovr_valid_drop", valid, 0);
`ifdef UART_RX_MAJORITY_EN
    exp_glitch = 8'hF0;
`else
    exp_glitch = 8'hF8;
`endif
    snap();
    frame(8'hF0, -1, 1'b1, 3);
    bits(1'b1, 1);
    check("bit3_glitch_acc", n_acc - b_acc, 1);
    check("bit3_glitch_data", last_acc, exp_glitch);
    bits(1'b0, 1);
    bits(1'b1, 3);
    reset = 1'b1;
    #1;
    check("midrst_valid", valid, 0);
    check("midrst_data", data, 0);
    repeat (2) tick(1'b1);
    reset = 1'b0;
    bits(1'b1, 2);
    snap();
    frame(8'h5A, -1, 1'b1, -1);
    bits(1'b1, 1);
    check("post_rst_acc", n_acc - b_acc, 1);
    check("post_rst_data", last_acc, 8'h5A);
    check("post_rst_errs", (n_perr - b_perr) + (n_ferr - b_ferr) + (n_ovr - b_ovr), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
